// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth signed multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Each CALC cycle does one add, subtract or pass through the carry-select adder,
// followed by a one-bit arithmetic right shift of {A,Q,q_m1}.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   a, b               signed multiplicand / multiplier
//   out_valid/out_ready result handshake (valid only in DONE)
//   product            registered signed product, held until the next result
//   busy               high in CALC and DONE
// Also contains the adder datapath (carry_select_adder) and its block cell (csa_block).

// One carry-select block: both carry-in cases are precomputed, and the true
// carry picks one of them.
module csa_block #(
    parameter int BW = 4
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [BW-1:0] s0,
    output logic          c0,
    output logic [BW-1:0] s1,
    output logic          c1
);
    assign {c0, s0} = {1'b0, a} + {1'b0, b};
    assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{BW{1'b0}}, 1'b1};
endmodule

// WIDTH-bit carry-select adder built from WIDTH/BLK block cells.
// overflow is the signed overflow of a + b + cin.
module carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NB = WIDTH / BLK;

    logic [NB-1:0][BLK-1:0] s0, s1;
    logic [NB-1:0]          c0, c1;
    logic [NB:0]            c;

    assign c[0] = cin;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        csa_block #(.BW(BLK)) u_blk (
            .a  (a[i*BLK +: BLK]),
            .b  (b[i*BLK +: BLK]),
            .s0 (s0[i]),
            .c0 (c0[i]),
            .s1 (s1[i]),
            .c1 (c1[i])
        );
        assign sum[i*BLK +: BLK] = c[i] ? s1[i] : s0[i];
        assign c[i+1]            = c[i] ? c1[i] : c0[i];
    end

    assign cout     = c[NB];
    // Operands of equal sign that produce a result of the opposite sign
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   m_q, acc_q, q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0] add_b, add_sum;
    logic             add_cin, add_ovf, unused_cout, sgn;

    // Booth recoding of {Q[0], q_m1}: 01 adds M, 10 subtracts M, else pass
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case ({q_q[0], qm1_q})
            2'b01:   add_b = m_q;
            2'b10: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    carry_select_adder #(.WIDTH(WIDTH), .BLK(4)) u_add (
        .a        (acc_q),
        .b        (add_b),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (unused_cout),
        .overflow (add_ovf)
    );

    // True sign of the unbounded sum; keeps M = -2^(W-1) exact
    assign sgn = add_sum[WIDTH-1] ^ add_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q    <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    m_q   <= a;
                    acc_q <= '0;
                    q_q   <= b;
                    qm1_q <= 1'b0;
                    cnt_q <= '0;
                end
                CALC: begin
                    // {A,Q,q_m1} <= {sgn, sum, Q} (arithmetic shift right by one)
                    acc_q <= {sgn, add_sum[WIDTH-1:1]};
                    q_q   <= {add_sum[0], q_q[WIDTH-1:1]};
                    qm1_q <= q_q[0];
                    cnt_q <= cnt_q + 1'b1;
                    // product only moves when the final iteration lands
                    if (cnt_q == CNT_LAST) prod_q <= {sgn, add_sum, q_q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign product = prod_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] product;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted op becomes visible 32 edges later as
    // the exact signed product, and stays until handed off.
    bit          m_busy = 1'b0;
    bit          m_ovalid = 1'b0;
    int          m_age = 0;
    logic [63:0] m_pending = '0;
    logic [63:0] m_prod = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_ovalid = 1'b0; m_age = 0; m_prod = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy    = 1'b1;
                m_age     = 0;
                m_pending = 64'(longint'($signed(a)) * longint'($signed(b)));
            end
        end else if (!m_ovalid) begin
            m_age++;
            if (m_age == 32) begin
                m_ovalid = 1'b1;
                m_prod   = m_pending;
            end
        end else if (out_ready) begin
            m_ovalid = 1'b0;
            m_busy   = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  64'(in_ready),  64'(!m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_ovalid));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("product",   product,        m_prod);
        end
    end

    // One full operation; hold = cycles of back-pressure with junk in_valid
    task automatic op(input logic [31:0] x, input logic [31:0] y, input int hold,
                      input bit use_lit, input logic [63:0] lit);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #2; t++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid  = 1'b1; a = x; b = y;
        out_ready = (hold == 0);
        @(posedge clk); #2;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk); #2; t++;
        end
        chk("latency", 64'(t), 64'd32);
        if (use_lit) chk("product_literal", product, lit);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #2;
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy",      64'(busy),      64'd0);
        chk("reset_product",   product,        64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        op(32'd3, 32'(-7), 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b1, 64'h3FFF_FFFF_0000_0001);
        op(32'h8000_0000, 32'h8000_0000, 0, 1'b1, 64'h4000_0000_0000_0000);
        op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 64'h0000_0000_8000_0000);
        op(32'd0, 32'd4561, 0, 1'b1, 64'h0);
        op(32'd52, 32'(-31), 10, 1'b1, 64'hFFFF_FFFF_FFFF_F9B4);

        // Abort mid-CALC: result must never be presented
        in_valid = 1'b1; a = 32'd152; b = 32'd2539;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_product",   product,        64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #2; end
        op(32'(-451), 32'd4498, 0, 1'b1, 64'hFFFF_FFFF_FFE1_0BCA);

        for (int k = 0; k < 30; k++)
            op(pick(), pick(), int'($urandom_range(0, 3)), 1'b0, 64'h0);

        repeat (3) begin @(posedge clk); #2; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Sequential 32×32 signed multiplier that drives the `carry_select_adder` as its only arithmetic datapath, one partial-product add or subtract per cycle. It uses radix-2 Booth recoding over 32 iterations and produces a 64-bit two's-complement product. The block sits directly upstream of the adder, supplying its `a`/`b`/`cin` operands every cycle and consuming its `sum`/`overflow`. Valid/ready handshakes on both sides make it a drop-in ALU multi-cycle unit.

## Interface

Parameters:
- `WIDTH`, 32, operand width. It must equal the adder width. Any other value is unsupported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operands `a`, `b` are valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  32  signed multiplicand.
- `b`  in  32  signed multiplier.
- `out_valid`  out  1  `product` is valid.
- `out_ready`  in  1  consumer accepts `product`.
- `product`  out  64  signed result, a×b.
- `busy`  out  1  high in CALC and DONE.

## Operation

- Internal registers:
  - `M[31:0]`, multiplicand.
  - `A[31:0]`, high accumulator.
  - `Q[31:0]`, low word / multiplier.
  - `q_m1`, Booth extra bit.
  - `cnt[5:0]`, iteration counter.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, load: `M`=a, `A`=0, `Q`=b, `q_m1`=0, `cnt`=0.
  - Then go to CALC.
- CALC, one iteration per cycle. The adder input `a` is driven with `A`. The other adder inputs depend on `{Q[0],q_m1}`:
  - 01 → add: adder b=`M`, cin=0.
  - 10 → subtract: adder b=~`M`, cin=1.
  - 00 / 11 → pass: adder b=0, cin=0.
- Shift after each add:
  - Let `s` = adder `sum` and `sgn` = `sum[31] ^ overflow`. `sgn` is the true sign of the 33-bit result, which keeps the result correct when `M` = −2^31.
  - Perform a 65-bit arithmetic right shift: `{A,Q,q_m1}` ← `{sgn, s, Q}`.
  - `cnt` increments.
- Exit CALC: after the iteration where `cnt`==31, go to DONE.
- DONE:
  - `out_valid`=1 and `product`={`A`,`Q`}.
  - Hold until `out_ready`=1, then go to IDLE.
- `a`, `b`, and `in_valid` are ignored outside IDLE.
- Adder `cout` is unused.
- Width rules:
  - All arithmetic is two's complement.
  - The product is exact for every operand pair, with no saturation.
  - The −2^31 × −2^31 case yields +2^62 without error.

## Timing

- Reset (`rst_n`=0 sampled at an edge) puts the block in:
  - state IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `product`=0, `A`=`Q`=`M`=0, `q_m1`=0, `cnt`=0.
- Reset mid-CALC or mid-DONE aborts the operation. The result is discarded and never presented.
- Latency:
  - Operands are accepted at edge E.
  - CALC iterations occur at edges E+1 … E+32.
  - `out_valid` is high from edge E+32.
- DONE→IDLE occurs at the edge where `out_valid && out_ready`. `in_ready` goes high the cycle after.
- There is no accept in the same cycle as result hand-off. Minimum initiation interval is 34 cycles.
- `product` is held stable while `out_valid && !out_ready`, for any number of cycles.
- `in_ready`, `out_valid`, and `busy` are registered-state decodes with no combinational path from `in_valid` or `out_ready`.
- `product` is a direct register output and does not change while `out_valid`=0, except on reset.

## Test plan

- a=3, b=−7, `out_ready`=1:
  - `product`=0xFFFF_FFFF_FFFF_FFEB (−21);
  - `out_valid` rises exactly 32 cycles after the accept edge.
- a=2147483647, b=2147483647 → `product`=0x3FFF_FFFF_0000_0001.
- Overflow path:
  - a=−2147483648, b=−2147483648 → `product`=0x4000_0000_0000_0000.
  - a=−2147483648, b=−1 → `product`=0x0000_0000_8000_0000.
- a=0, b=4561 → `product`=0.
- Back-pressure:
  - a=52, b=−31 with `out_ready`=0 for 10 cycles: `product`=0xFFFF_FFFF_FFFF_F9B4 (−1612) held stable, `out_valid`=1, `in_ready`=0, and a new `in_valid` is ignored.
  - Then `out_ready`=1 → `out_valid` falls and `in_ready` rises the next cycle.
- Reset abort:
  - Accept a=152, b=2539, then assert `rst_n`=0 at iteration 10 → all outputs take their reset values and `out_valid` never asserts.
  - Next op a=−451, b=4498 → `product`=−2028598 (0xFFFF_FFFF_FFE1_0BCA).
